// File: rtl/mc_ctrl_seq_if.sv
// Control bus between the multicycle sequencer (master) and the datapath (slave).
interface mc_ctrl_seq_if #(parameter int OPCODE_W = 6);
  logic [OPCODE_W-1:0] opcode;
  logic                instr_ready;
  logic                zero_flag;
  logic                carry_flag;
  logic                neg_flag;
  logic                mem_ready;
  logic [2:0]          state;
  logic                ir_we;
  logic                pc_we;
  logic [1:0]          pc_src;
  logic                j_src;
  logic                ext_src;
  logic                reg_des;
  logic                alu_src;
  logic [1:0]          wb_data;
  logic                reg_w1;
  logic                reg_w2;
  logic                mem_read;
  logic                mem_write;
  logic                illegal_op;
  logic                mem_timeout;

  modport master (
    input  opcode, instr_ready, zero_flag, carry_flag, neg_flag, mem_ready,
    output state, ir_we, pc_we, pc_src, j_src, ext_src, reg_des, alu_src,
           wb_data, reg_w1, reg_w2, mem_read, mem_write, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, instr_ready, zero_flag, carry_flag, neg_flag, mem_ready,
    input  state, ir_we, pc_we, pc_src, j_src, ext_src, reg_des, alu_src,
           wb_data, reg_w1, reg_w2, mem_read, mem_write, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mc_ctrl_seq.sv
// Multicycle IF/ID/EX/MEM/WB sequencer: latches the opcode once per instruction and
// decodes all strobes from registered state/op_q; memory wait-states time out into TRAP.
module mc_ctrl_seq #(
  parameter int OPCODE_W     = 6,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LWPOI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BGT   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BLT   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_PUSH  = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_POP   = OPCODE_W'(16);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;

  logic       ir_we, pc_we, j_src, ext_src, reg_des, alu_src;
  logic       reg_w1, reg_w2, mem_read, mem_write, taken;
  logic [1:0] pc_src, wb_data;
  logic       unused_carry;

  assign unused_carry = bus.carry_flag;

  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_BGT:  taken = !bus.neg_flag && !bus.zero_flag;
      OP_BLT:  taken = bus.neg_flag;
      OP_BEQ:  taken = bus.zero_flag;
      OP_BNE:  taken = !bus.zero_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    j_src     = 1'b0;
    ext_src   = 1'b0;
    reg_des   = 1'b0;
    alu_src   = 1'b0;
    wb_data   = 2'd0;
    reg_w1    = 1'b0;
    reg_w2    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      S_IF: begin
        ir_we = bus.instr_ready;
        if (bus.instr_ready) begin
          op_d    = bus.opcode;
          state_d = S_ID;
        end
      end

      S_ID: begin
        if (op_q > OP_POP) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else if (op_q == OP_JMP) begin
          pc_we   = 1'b1;
          pc_src  = 2'd1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (op_q <= OP_ANDI) begin
          // R-type keeps all selects at 0; immediates switch in the extended operand
          if (op_q > OPCODE_W'(2)) begin
            reg_des = 1'b1;
            alu_src = 1'b1;
            ext_src = 1'b1;
          end
          state_d = S_WB;
        end else if (op_q >= OP_BGT && op_q <= OP_BNE) begin
          ext_src = 1'b1;
          pc_we   = 1'b1;
          pc_src  = taken ? 2'd2 : 2'd0;
          state_d = S_IF;
        end else begin
          alu_src = 1'b1;
          ext_src = 1'b1;
          state_d = S_MEM;
        end
      end

      S_MEM: begin
        mem_read  = (op_q == OP_LW) || (op_q == OP_LWPOI) ||
                    (op_q == OP_RET) || (op_q == OP_POP);
        mem_write = (op_q == OP_SW) || (op_q == OP_CALL) || (op_q == OP_PUSH);
        if (bus.mem_ready) begin
          cnt_d = '0;
          case (op_q)
            OP_LW, OP_LWPOI, OP_POP: state_d = S_WB;
            OP_CALL: begin
              pc_we   = 1'b1;
              pc_src  = 2'd1;
              state_d = S_IF;
            end
            OP_RET: begin
              pc_we   = 1'b1;
              pc_src  = 2'd1;
              j_src   = 1'b1;
              state_d = S_IF;
            end
            default: begin
              pc_we   = 1'b1;
              state_d = S_IF;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_TRAP;
          end
        end
      end

      S_WB: begin
        pc_we   = 1'b1;
        reg_w1  = (op_q <= OP_LWPOI) || (op_q == OP_POP);
        reg_w2  = (op_q == OP_LWPOI);
        wb_data = ((op_q == OP_LW) || (op_q == OP_LWPOI) || (op_q == OP_POP)) ? 2'd1 : 2'd0;
        state_d = S_IF;
      end

      S_TRAP: state_d = S_TRAP;

      default: begin
        illegal_d = 1'b1;
        state_d   = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      op_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_src      = pc_src;
  assign bus.j_src       = j_src;
  assign bus.ext_src     = ext_src;
  assign bus.reg_des     = reg_des;
  assign bus.alu_src     = alu_src;
  assign bus.wb_data     = wb_data;
  assign bus.reg_w1      = reg_w1;
  assign bus.reg_w2      = reg_w2;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Scoreboarded directed bench for mc_ctrl_seq: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_mc_ctrl_seq;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       j_src;
    logic       ext_src;
    logic       reg_des;
    logic       alu_src;
    logic [1:0] wb_data;
    logic       reg_w1;
    logic       reg_w2;
    logic       mem_read;
    logic       mem_write;
    logic       illegal_op;
    logic       mem_timeout;
  } obs_t;

  localparam int TO  = 1 << 0;
  localparam int IL  = 1 << 1;
  localparam int MW  = 1 << 2;
  localparam int MR  = 1 << 3;
  localparam int W2  = 1 << 4;
  localparam int W1  = 1 << 5;
  localparam int WB1 = 1 << 6;
  localparam int AS  = 1 << 8;
  localparam int RD  = 1 << 9;
  localparam int ES  = 1 << 10;
  localparam int JS  = 1 << 11;
  localparam int PS1 = 1 << 12;
  localparam int PS2 = 2 << 12;
  localparam int PCW = 1 << 14;
  localparam int IRW = 1 << 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  mc_ctrl_seq_if #(.OPCODE_W(6)) bus ();

  mc_ctrl_seq #(.OPCODE_W(6), .MEM_WAIT_MAX(15), .WAIT_CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int st, input int m);
    return obs_t'((st << 16) | m);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state       = bus.state;
    o.ir_we       = bus.ir_we;
    o.pc_we       = bus.pc_we;
    o.pc_src      = bus.pc_src;
    o.j_src       = bus.j_src;
    o.ext_src     = bus.ext_src;
    o.reg_des     = bus.reg_des;
    o.alu_src     = bus.alu_src;
    o.wb_data     = bus.wb_data;
    o.reg_w1      = bus.reg_w1;
    o.reg_w2      = bus.reg_w2;
    o.mem_read    = bus.mem_read;
    o.mem_write   = bus.mem_write;
    o.illegal_op  = bus.illegal_op;
    o.mem_timeout = bus.mem_timeout;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %05h want %05h (state got %0d want %0d)",
               tag, got, want, got.state, want.state);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) chk(tag_q.pop_front(), sample(), exp_q.pop_front());
    end
  end

  task automatic cyc(input bit ir, input bit zf, input bit nf, input bit mr,
                     input int st, input int m, input string tag);
    bus.instr_ready = ir;
    bus.zero_flag   = zf;
    bus.neg_flag    = nf;
    bus.mem_ready   = mr;
    exp_q.push_back(mk(st, m));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    #2;
    chk("reset_now", sample(), mk(0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.opcode      = '0;
    bus.instr_ready = 1'b0;
    bus.zero_flag   = 1'b0;
    bus.carry_flag  = 1'b0;
    bus.neg_flag    = 1'b0;
    bus.mem_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", sample(), mk(0, 0));
    rst_n = 1'b1;

    // Fetch stall
    cyc(0, 0, 0, 0, 0, 0, "if_stall0");
    cyc(0, 0, 0, 0, 0, 0, "if_stall1");

    // ADD
    bus.opcode = 6'd0;
    cyc(1, 0, 0, 0, 0, IRW, "add_if");
    cyc(0, 0, 0, 0, 1, 0, "add_id");
    cyc(0, 0, 0, 0, 2, 0, "add_ex");
    cyc(0, 0, 0, 0, 4, PCW | W1, "add_wb");

    // BEQ taken / not taken
    bus.opcode = 6'd10;
    cyc(1, 1, 0, 0, 0, IRW, "beq_t_if");
    cyc(0, 1, 0, 0, 1, 0, "beq_t_id");
    cyc(0, 1, 0, 0, 2, ES | PCW | PS2, "beq_t_ex");
    cyc(1, 0, 0, 0, 0, IRW, "beq_n_if");
    cyc(0, 0, 0, 0, 1, 0, "beq_n_id");
    cyc(0, 0, 0, 0, 2, ES | PCW, "beq_n_ex");

    // BLT taken, BGT taken, BNE not taken
    bus.opcode = 6'd9;
    cyc(1, 0, 1, 0, 0, IRW, "blt_if");
    cyc(0, 0, 1, 0, 1, 0, "blt_id");
    cyc(0, 0, 1, 0, 2, ES | PCW | PS2, "blt_ex");
    bus.opcode = 6'd8;
    cyc(1, 0, 0, 0, 0, IRW, "bgt_if");
    cyc(0, 0, 0, 0, 1, 0, "bgt_id");
    cyc(0, 0, 0, 0, 2, ES | PCW | PS2, "bgt_ex");
    bus.opcode = 6'd11;
    cyc(1, 1, 0, 0, 0, IRW, "bne_if");
    cyc(0, 1, 0, 0, 1, 0, "bne_id");
    cyc(0, 1, 0, 0, 2, ES | PCW, "bne_ex");

    // ADDI
    bus.opcode = 6'd3;
    cyc(1, 0, 0, 0, 0, IRW, "addi_if");
    cyc(0, 0, 0, 0, 1, 0, "addi_id");
    cyc(0, 0, 0, 0, 2, RD | AS | ES, "addi_ex");
    cyc(0, 0, 0, 0, 4, PCW | W1, "addi_wb");

    // JMP resolves in ID
    bus.opcode = 6'd12;
    cyc(1, 0, 0, 0, 0, IRW, "jmp_if");
    cyc(0, 0, 0, 0, 1, PCW | PS1, "jmp_id");

    // LWPOI with three wait states
    bus.opcode = 6'd6;
    cyc(1, 0, 0, 0, 0, IRW, "lwpoi_if");
    cyc(0, 0, 0, 0, 1, 0, "lwpoi_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "lwpoi_ex");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 3, MR, "lwpoi_mem_wait");
    cyc(0, 0, 0, 1, 3, MR, "lwpoi_mem_done");
    cyc(0, 0, 0, 0, 4, PCW | W1 | W2 | WB1, "lwpoi_wb");

    // SW with one wait state
    bus.opcode = 6'd7;
    cyc(1, 0, 0, 0, 0, IRW, "sw_if");
    cyc(0, 0, 0, 0, 1, 0, "sw_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "sw_ex");
    cyc(0, 0, 0, 0, 3, MW, "sw_mem_wait");
    cyc(0, 0, 0, 1, 3, MW | PCW, "sw_mem_done");

    // CALL, RET, POP with zero wait
    bus.opcode = 6'd13;
    cyc(1, 0, 0, 0, 0, IRW, "call_if");
    cyc(0, 0, 0, 0, 1, 0, "call_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "call_ex");
    cyc(0, 0, 0, 1, 3, MW | PCW | PS1, "call_mem");
    bus.opcode = 6'd14;
    cyc(1, 0, 0, 0, 0, IRW, "ret_if");
    cyc(0, 0, 0, 0, 1, 0, "ret_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "ret_ex");
    cyc(0, 0, 0, 1, 3, MR | PCW | PS1 | JS, "ret_mem");
    bus.opcode = 6'd16;
    cyc(1, 0, 0, 0, 0, IRW, "pop_if");
    cyc(0, 0, 0, 0, 1, 0, "pop_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "pop_ex");
    cyc(0, 0, 0, 1, 3, MR, "pop_mem");
    cyc(0, 0, 0, 0, 4, PCW | W1 | WB1, "pop_wb");

    // Reset asserted in the middle of a SW memory wait
    bus.opcode = 6'd7;
    cyc(1, 0, 0, 0, 0, IRW, "swr_if");
    cyc(0, 0, 0, 0, 1, 0, "swr_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "swr_ex");
    bus.mem_ready = 1'b0;
    exp_q.push_back(mk(3, MW));
    tag_q.push_back("swr_mem");
    @(negedge clk);
    #2;
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, "swr_after");

    // Illegal opcode traps after ID and stays trapped
    bus.opcode = 6'h3F;
    cyc(1, 0, 0, 0, 0, IRW, "ill_if");
    cyc(1, 0, 0, 0, 1, 0, "ill_id");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 5, IL, "ill_trap");
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, "ill_cleared");

    // LW never completes: 15 MEM cycles then timeout
    bus.opcode = 6'd5;
    cyc(1, 0, 0, 0, 0, IRW, "to_if");
    cyc(0, 0, 0, 0, 1, 0, "to_id");
    cyc(0, 0, 0, 0, 2, AS | ES, "to_ex");
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 3, MR, "to_mem_wait");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 5, TO, "to_trap");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
